// File: rtl/ic_rep_arbiter.sv
// Round-robin arbiter sharing the ic_download path between the local-memory
// line source and the IN_rep flit fifo, with over-length packet protection.
module ic_rep_arbiter #(
    parameter int unsigned MAX_FLITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] mem_flits,
    input  logic         v_mem_flits,
    output logic         mem_ack,
    input  logic [15:0]  fifo_flit,
    input  logic [1:0]   fifo_ctrl,
    input  logic         fifo_empty,
    output logic         fifo_pop,
    input  logic [1:0]   ic_download_state,
    output logic [127:0] mem_flits_ic,
    output logic         v_mem_flits_ic,
    output logic [15:0]  rep_flit_ic,
    output logic         v_rep_flit_ic,
    output logic [1:0]   rep_ctrl_ic,
    output logic         arb_busy,
    output logic         err_overlen
);

    localparam int unsigned CNT_W = $clog2(MAX_FLITS + 1);
    localparam logic [1:0]  CTRL_TAIL = 2'b11;
    localparam logic [1:0]  DS_IDLE   = 2'b00;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        MEM_GNT    = 2'b01,
        REP_STREAM = 2'b10,
        WAIT_DONE  = 2'b11
    } state_t;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_REP = 1'b1
    } src_t;

    state_t           state, state_nxt;
    src_t             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] flit_cnt, flit_cnt_nxt;
    logic             set_err;
    logic             fwd;
    logic             force_tail;
    logic             mem_req;
    logic             rep_req;

    assign mem_req  = v_mem_flits;
    assign rep_req  = !fifo_empty;
    assign arb_busy = (state != IDLE);

    // Grant decision, flit forwarding and next-state logic.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        flit_cnt_nxt   = flit_cnt;
        set_err        = 1'b0;
        fwd            = 1'b0;
        force_tail     = 1'b0;
        mem_ack        = 1'b0;
        v_mem_flits_ic = 1'b0;
        mem_flits_ic   = '0;
        fifo_pop       = 1'b0;
        v_rep_flit_ic  = 1'b0;
        rep_flit_ic    = '0;
        rep_ctrl_ic    = '0;

        case (state)
            IDLE: begin
                if (ic_download_state == DS_IDLE) begin
                    if (mem_req && (!rep_req || last_grant == SRC_REP)) begin
                        mem_ack        = 1'b1;
                        v_mem_flits_ic = 1'b1;
                        mem_flits_ic   = mem_flits;
                        last_grant_nxt = SRC_MEM;
                        state_nxt      = WAIT_DONE;
                    end else if (rep_req) begin
                        fwd            = 1'b1;
                        flit_cnt_nxt   = CNT_W'(1);
                        last_grant_nxt = SRC_REP;
                        state_nxt      = REP_STREAM;
                    end
                end
            end
            REP_STREAM: begin
                if (rep_req) begin
                    fwd = 1'b1;
                    if (fifo_ctrl == CTRL_TAIL) begin
                        flit_cnt_nxt = '0;
                        state_nxt    = WAIT_DONE;
                    end else if (flit_cnt == CNT_W'(MAX_FLITS - 1)) begin
                        // Truncate the packet: the downstream sees a tail now.
                        force_tail   = 1'b1;
                        set_err      = 1'b1;
                        flit_cnt_nxt = '0;
                        state_nxt    = WAIT_DONE;
                    end else begin
                        flit_cnt_nxt = flit_cnt + CNT_W'(1);
                    end
                end
            end
            WAIT_DONE: begin
                if (ic_download_state == DS_IDLE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (fwd) begin
            fifo_pop      = 1'b1;
            v_rep_flit_ic = 1'b1;
            rep_flit_ic   = fifo_flit;
            rep_ctrl_ic   = force_tail ? CTRL_TAIL : fifo_ctrl;
        end

        // Keep every output quiet while reset is held.
        if (rst) begin
            mem_ack        = 1'b0;
            v_mem_flits_ic = 1'b0;
            mem_flits_ic   = '0;
            fifo_pop       = 1'b0;
            v_rep_flit_ic  = 1'b0;
            rep_flit_ic    = '0;
            rep_ctrl_ic    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= SRC_REP;
            flit_cnt    <= '0;
            err_overlen <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            flit_cnt   <= flit_cnt_nxt;
            if (set_err) begin
                err_overlen <= 1'b1;
            end
        end
    end

endmodule
